alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width.
REQ-002 Parameter: OP_W, 4, ALU control-signal width.
REQ-003 Ports (N = 0,1; one clock; reset asynchronous, active-high):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- reqN_valid  in  1  requester N has an operation.
- reqN_ready  out  1  requester N accepted this cycle.
- reqN_op  in  OP_W  ALU control code.
- reqN_a / reqN_b  in  DATA_W  operands.
- rspN_valid  out  1  result for requester N is held.
- rspN_ready  in  1  requester N takes the result.
- rspN_data  out  DATA_W  result.
- alu_ctrl  out  OP_W  to ALU control_signal.
- alu_a / alu_b  out  DATA_W  to ALU operands.
- alu_result  in  DATA_W  from combinational ALU output.
- busy  out  1  FSM not in IDLE.

Function
REQ-004 FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-005 IDLE: if any reqN_valid, pick winner per REQ-009; assert winner's reqN_ready combinationally that cycle only; latch op, a, b and winner id; go EXEC. No valid: stay IDLE.
REQ-006 EXEC (exactly one cycle): alu_ctrl/alu_a/alu_b driven from latched registers; alu_result captured into result register at cycle end; go RESP.
REQ-007 RESP: rspN_valid high for latched winner only, rspN_data = captured result, stable until rspN_ready; on rspN_valid && rspN_ready go IDLE.
REQ-008 Latency: accept at edge k -> rspN_valid visible after edge k+2; max throughput one op per 3 cycles with rspN_ready tied high.
REQ-009 Arbitration: round-robin; single requester always wins; both valid -> the one not granted last wins; pointer updates only on grant.
REQ-010 reqN_ready never asserted outside IDLE; requests arriving during EXEC/RESP wait, no loss.
REQ-011 Outside EXEC, alu_ctrl/alu_a/alu_b hold last latched values (no toggling when idle).
REQ-012 Undefined op codes passed unchanged; result is whatever ALU returns (zero per its default).
REQ-013 rspN_ready ignored when rspN_valid low; rspN_data for non-winner is don't-care but driven to zero.

Reset
REQ-014 rst asynchronously forces IDLE; all reqN_ready, rspN_valid, busy = 0; rspN_data, alu_ctrl, alu_a, alu_b = 0; RR pointer favours requester 0.
REQ-015 Reset mid-EXEC or mid-RESP discards the operation; no response produced after release.

Configuration
REQ-016 Macro ALU_ARB_FIXED_PRIO_EN: defined -> requester 0 always wins when both valid, RR pointer removed; undefined -> round-robin per REQ-009.

Structure
REQ-017 ALU control codes (AND, OR, ADD, SUB, SLT, NOR, SLL, SRL) and FSM state encodings live in the shared ALU package/defines, not local.
REQ-018 One sub-module: arb_rr2 (2-way grant with last-grant pointer, fixed-priority under the macro).

Verification
REQ-019 Single op: req0 ADD a=5 b=7 -> req0_ready same cycle; rsp0_valid two edges later, rsp0_data=12.
REQ-020 Contention: req0 and req1 valid from reset, rsp ready high -> grants 0,1,0,1; data checked per op (SUB 10-3=7, SLL 1<<4=16).
REQ-021 Backpressure: rsp1_ready low 5 cycles -> rsp1_valid/data stable, busy=1, no reqN_ready during hold.
REQ-022 Reset in EXEC: assert rst -> outputs zero immediately; after release no rsp_valid without new request.
REQ-023 With ALU_ARB_FIXED_PRIO_EN: both valid continuously -> requester 0 granted every time, requester 1 never.
REQ-024 Idle stability: no requests 20 cycles after one op -> alu_ctrl/alu_a/alu_b unchanged, busy=0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU control codes, FSM encodings and default widths for the ALU arbiter.
package alu_arbiter_pkg;

  localparam int unsigned ALU_DATA_W = 32;
  localparam int unsigned ALU_OP_W   = 4;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_SLL = 4'b1000,
    ALU_SRL = 4'b1001,
    ALU_NOR = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_arb_rr2.sv
// arb_rr2: two-way grant. Round-robin on a last-grant pointer by default;
// with ALU_ARB_FIXED_PRIO_EN defined, requester 0 always wins and the pointer is removed.
module arb_rr2 (
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       update,
`endif
  input  logic [1:0] req,
  output logic [1:0] grant_c
);

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic last_q;

  // Pointer remembers the last winner; reset value makes requester 0 favoured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (update) begin
      last_q <= grant_c[1];
    end
  end

  // Lone requester wins; on contention the one not granted last wins.
  always_comb begin
    grant_c = 2'b00;
    case (req)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11:   grant_c = last_q ? 2'b01 : 2'b10;
      default: grant_c = 2'b00;
    endcase
  end
`else
  // Requester 0 has absolute priority.
  always_comb begin
    grant_c = 2'b00;
    if (req[0]) begin
      grant_c = 2'b01;
    end else if (req[1]) begin
      grant_c = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters, one op in flight.
// Optional build macro ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0) arbitration.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned OP_W   = ALU_OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [OP_W-1:0]   alu_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic [1:0]        grant_c;
  logic              grant_en;
  logic              win_q;
  logic              rsp_take_c;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q, b_q;

  arb_rr2 u_arb (
`ifndef ALU_ARB_FIXED_PRIO_EN
    .clk     (clk),
    .rst     (rst),
    .update  (grant_en),
`endif
    .req     ({req1_valid, req0_valid}),
    .grant_c (grant_c)
  );

  // Only the latched winner's ready can complete the response.
  assign rsp_take_c = win_q ? rsp1_ready : rsp0_ready;

  // ALU inputs come straight from the operand latches so they hold when idle.
  assign alu_ctrl = op_q;
  assign alu_a    = a_q;
  assign alu_b    = b_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and the same-cycle accept handshake.
  always_comb begin
    state_d    = state_q;
    grant_en   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|grant_c) begin
          grant_en   = 1'b1;
          req0_ready = grant_c[0];
          req1_ready = grant_c[1];
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_take_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch the winning operation on grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q <= 1'b0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (grant_en) begin
      win_q <= grant_c[1];
      op_q  <= grant_c[1] ? req1_op : req0_op;
      a_q   <= grant_c[1] ? req1_a  : req0_a;
      b_q   <= grant_c[1] ? req1_b  : req0_b;
    end
  end

  // Capture the ALU result at the end of EXEC and hold it until the winner takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
      busy       <= 1'b0;
    end else begin
      busy <= (state_d != ST_IDLE);
      if (state_q == ST_EXEC) begin
        rsp0_valid <= ~win_q;
        rsp1_valid <= win_q;
        rsp0_data  <= win_q ? '0 : alu_result;
        rsp1_data  <= win_q ? alu_result : '0;
      end else if ((state_q == ST_RESP) && rsp_take_c) begin
        rsp0_valid <= 1'b0;
        rsp1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural combinational ALU.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          req;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .busy(busy)
  );

  // Reference ALU: unknown codes return zero.
  always_comb begin
    alu_result = 32'd0;
    case (alu_ctrl)
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_SLT: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      ALU_NOR: alu_result = ~(alu_a | alu_b);
      ALU_SLL: alu_result = alu_a << alu_b[4:0];
      ALU_SRL: alu_result = alu_a >> alu_b[4:0];
      default: alu_result = 32'd0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input int n, input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  // One isolated operation: accept, EXEC, then response two edges after the accept.
  task automatic do_op(input int n, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    @(posedge clk); #1;
    drive(n, 1'b1, op, a, b);
    @(negedge clk);
    check("accept_ready", 32'(n == 0 ? req0_ready : req1_ready), 32'd1);
    check("accept_other_ready", 32'(n == 0 ? req1_ready : req0_ready), 32'd0);
    @(posedge clk); #1;
    drive(n, 1'b0, op, a, b);
    @(negedge clk);
    check("exec_alu_a", alu_a, a);
    check("exec_alu_ctrl", 32'(alu_ctrl), 32'(op));
    check("exec_no_ready", 32'(req0_ready | req1_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rsp_valid", 32'(n == 0 ? rsp0_valid : rsp1_valid), 32'd1);
    check("rsp_other_valid", 32'(n == 0 ? rsp1_valid : rsp0_valid), 32'd0);
    check("rsp_data", n == 0 ? rsp0_data : rsp1_data, exp);
    check("rsp_other_data", n == 0 ? rsp1_data : rsp0_data, 32'd0);
  endtask

  initial begin
    int grants;
    int exp_seq [4];
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    vecs[0] = '{0, ALU_ADD, 32'd5,          32'd7,  32'd12};
    vecs[1] = '{1, ALU_SUB, 32'd10,         32'd3,  32'd7};
    vecs[2] = '{0, ALU_AND, 32'hFF00_FF00,  32'h0FF0_0FF0, 32'h0F00_0F00};
    vecs[3] = '{1, ALU_OR,  32'h0000_00F0,  32'h0000_000F, 32'h0000_00FF};
    vecs[4] = '{0, ALU_SLT, 32'hFFFF_FFFF,  32'd1,  32'd1};
    vecs[5] = '{1, ALU_NOR, 32'd0,          32'd0,  32'hFFFF_FFFF};
    vecs[6] = '{0, ALU_SLL, 32'd1,          32'd4,  32'd16};
    vecs[7] = '{1, ALU_SRL, 32'h8000_0000,  32'd31, 32'd1};
    vecs[8] = '{0, 4'hF,    32'd9,          32'd9,  32'd0};

    rst = 1'b1;
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    check("reset_alu_a", alu_a, 32'd0);
    check("reset_rsp0_data", rsp0_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Contention from reset: grant order alternates (or stays on 0 under fixed priority).
    @(posedge clk); #1;
    drive(0, 1'b1, ALU_SUB, 32'd10, 32'd3);
    drive(1, 1'b1, ALU_SLL, 32'd1, 32'd4);
    grants = 0;
    for (int cyc = 0; cyc < 30 && grants < 4; cyc++) begin
      @(negedge clk);
      if (rsp0_valid) check("cont_rsp0_data", rsp0_data, 32'd7);
      if (rsp1_valid) check("cont_rsp1_data", rsp1_data, 32'd16);
      if (req0_ready || req1_ready) begin
        check("cont_single_grant", 32'(req0_ready & req1_ready), 32'd0);
        check("cont_grant_id", 32'(req1_ready ? 1 : 0), 32'(exp_seq[grants]));
        grants++;
      end
    end
    check("cont_grant_count", 32'(grants), 32'd4);
    @(posedge clk); #1;
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
    for (int cyc = 0; cyc < 10 && busy; cyc++) begin
      @(negedge clk);
      if (rsp0_valid) check("drain_rsp0_data", rsp0_data, 32'd7);
      if (rsp1_valid) check("drain_rsp1_data", rsp1_data, 32'd16);
    end
    check("drain_idle", 32'(busy), 32'd0);

    // Directed single-requester vectors.
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].req, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // Backpressure on requester 1 while requester 0 waits.
    rsp1_ready = 1'b0;
    @(posedge clk); #1;
    drive(1, 1'b1, ALU_ADD, 32'd100, 32'd23);
    @(negedge clk);
    check("bp_accept1", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
    drive(0, 1'b1, ALU_ADD, 32'd1, 32'd1);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp1_valid", 32'(rsp1_valid), 32'd1);
      check("bp_rsp1_data", rsp1_data, 32'd123);
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_no_ready", 32'(req0_ready | req1_ready), 32'd0);
    end
    rsp1_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_rsp1_dropped", 32'(rsp1_valid), 32'd0);
    check("bp_waiter_accept", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("bp_waiter_valid", 32'(rsp0_valid), 32'd1);
    check("bp_waiter_data", rsp0_data, 32'd2);

    // Reset asserted during EXEC discards the operation.
    @(posedge clk); #1;
    drive(0, 1'b1, ALU_ADD, 32'd5, 32'd7);
    @(negedge clk);
    check("rx_accept", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rx_busy", 32'(busy), 32'd0);
    check("rx_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    check("rx_alu_a", alu_a, 32'd0);
    check("rx_alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("rx_rsp0_data", rsp0_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rx_no_rsp", 32'({rsp1_valid, rsp0_valid, busy}), 32'd0);
    end

    // ALU inputs hold the last operation while idle.
    do_op(0, ALU_AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0);
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_alu_ctrl", 32'(alu_ctrl), 32'(ALU_AND));
      check("idle_alu_a", alu_a, 32'h0000_F0F0);
      check("idle_alu_b", alu_b, 32'h0000_0FF0);
      check("idle_busy", 32'(busy), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
